// File: rtl/cv32e40p_rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package cv32e40p_rf_arb_pkg;

  localparam int RF_ADDR_W         = 6;
  localparam int RF_DATA_W         = 32;
  localparam int RF_ARB_FIFO_DEPTH = 2;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_APU = 2;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wreq_t;

endpackage

// File: rtl/cv32e40p_rf_arb_fifo.sv
// Per-requester write buffer; exposes its storage and occupancy mask for the pending scoreboard.
module cv32e40p_rf_arb_fifo
  import cv32e40p_rf_arb_pkg::*;
#(
  parameter int  DEPTH = RF_ARB_FIFO_DEPTH,
  parameter type T     = rf_wreq_t
) (
  input  logic               clk_int,
  input  logic               rst_n,
  input  logic               push_i,
  input  T                   data_i,
  input  logic               pop_i,
  output T                   head_o,
  output logic               full_o,
  output logic               empty_o,
  output T     [DEPTH-1:0]   mem_o,
  output logic [DEPTH-1:0]   vld_o
);

  localparam int PW = $clog2(DEPTH);

  T     [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A push while full is legal when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rptr_q];
  assign mem_o   = mem_q;

  always_comb begin
    vld_o = '0;
    for (int i = 0; i < DEPTH; i++)
      vld_o[i] = ({1'b0, PW'(i) - rptr_q} < cnt_q);
  end

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_int) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/cv32e40p_rf_wport_arbiter.sv
// Merges NUM_REQ buffered write streams onto two register-file write ports, round-robin.
// Define CV32E40P_RF_ARB_SCOREBOARD_EN to build the pending_o per-register scoreboard.
module cv32e40p_rf_wport_arbiter
  import cv32e40p_rf_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int NUM_REQ    = 3,
  parameter int FIFO_DEPTH = RF_ARB_FIFO_DEPTH
) (
  input  logic                                clk_int,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  output logic                                we_a_o,
  output logic [ADDR_WIDTH-1:0]               waddr_a_o,
  output logic [DATA_WIDTH-1:0]               wdata_a_o,
  output logic                                we_b_o,
  output logic [ADDR_WIDTH-1:0]               waddr_b_o,
  output logic [DATA_WIDTH-1:0]               wdata_b_o,
  output logic [2**ADDR_WIDTH-1:0]            pending_o,
  output logic                                busy_o
);

  localparam int RRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Same {addr, data} layout as rf_wreq_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wreq_t;

  wreq_t [NUM_REQ-1:0]                 head;
  wreq_t [NUM_REQ-1:0][FIFO_DEPTH-1:0] ent;
  logic  [NUM_REQ-1:0][FIFO_DEPTH-1:0] ent_vld;
  logic  [NUM_REQ-1:0]                 full, empty, push, pop;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    assign push[g] = req_valid_i[g] & ~full[g];
    cv32e40p_rf_arb_fifo #(.DEPTH(FIFO_DEPTH), .T(wreq_t)) u_fifo (
      .clk_int (clk_int),
      .rst_n   (rst_n),
      .push_i  (push[g]),
      .data_i  (wreq_t'({req_addr_i[g], req_data_i[g]})),
      .pop_i   (pop[g]),
      .head_o  (head[g]),
      .full_o  (full[g]),
      .empty_o (empty[g]),
      .mem_o   (ent[g]),
      .vld_o   (ent_vld[g])
    );
  end

  assign req_ready_o = ~full;
  assign busy_o      = ~&empty;

  logic [RRW-1:0] rr_q, rr_d, idx;
  logic           ga_vld, gb_vld;
  wreq_t          ga, gb;

  // Walk heads from rr_q; a head colliding with port A's address is skipped for B and stays queued.
  always_comb begin
    pop    = '0;
    ga_vld = 1'b0;
    gb_vld = 1'b0;
    ga     = '0;
    gb     = '0;
    rr_d   = rr_q;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = RRW'((int'(rr_q) + k) % NUM_REQ);
      if (!empty[idx]) begin
        if (!ga_vld) begin
          ga_vld   = 1'b1;
          ga       = head[idx];
          pop[idx] = 1'b1;
          rr_d     = RRW'((int'(idx) + 1) % NUM_REQ);
        end else if (!gb_vld && head[idx].addr != ga.addr) begin
          gb_vld   = 1'b1;
          gb       = head[idx];
          pop[idx] = 1'b1;
          rr_d     = RRW'((int'(idx) + 1) % NUM_REQ);
        end
      end
    end
  end

  logic                  we_a_q, we_b_q;
  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_b_q;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_b_q;

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= '0;
      we_a_q    <= 1'b0;
      we_b_q    <= 1'b0;
      waddr_a_q <= '0;
      waddr_b_q <= '0;
      wdata_a_q <= '0;
      wdata_b_q <= '0;
    end else begin
      rr_q   <= rr_d;
      // x0 pops use up the slot but never write
      we_a_q <= ga_vld && (ga.addr != '0);
      we_b_q <= gb_vld && (gb.addr != '0);
      if (ga_vld) begin
        waddr_a_q <= ga.addr;
        wdata_a_q <= ga.data;
      end
      if (gb_vld) begin
        waddr_b_q <= gb.addr;
        wdata_b_q <= gb.data;
      end
    end
  end

  assign we_a_o    = we_a_q;
  assign waddr_a_o = waddr_a_q;
  assign wdata_a_o = wdata_a_q;
  assign we_b_o    = we_b_q;
  assign waddr_b_o = waddr_b_q;
  assign wdata_b_o = wdata_b_q;

`ifdef CV32E40P_RF_ARB_SCOREBOARD_EN
  always_comb begin
    pending_o = '0;
    for (int r = 0; r < NUM_REQ; r++)
      for (int e = 0; e < FIFO_DEPTH; e++)
        if (ent_vld[r][e]) pending_o[ent[r][e].addr] = 1'b1;
    pending_o[0] = 1'b0;
  end
`else
  logic unused_sb;
  assign unused_sb = ^{ent, ent_vld};
  assign pending_o = '0;
`endif

endmodule

// File: doc/cv32e40p_rf_wport_arbiter.md
CV32E40P_RF_WPORT_ARBITER -- requirements
Module: cv32e40p_rf_wport_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6; register address width, bit 5 selects the FP bank.
REQ-002 SHALL have parameter DATA_WIDTH, default 32; write data width.
REQ-003 SHALL have parameter NUM_REQ, default 3; number of write requesters (0=ALU, 1=LSU, 2=APU).
REQ-004 SHALL have parameter FIFO_DEPTH, default 2; per-requester buffer entries, power of two, at least 2.
REQ-005 SHALL have port clk_int  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  in  NUM_REQ  per-requester write request.
REQ-007 SHALL have port req_ready_o  out  NUM_REQ  per-requester accept; high iff that FIFO is not full.
REQ-008 SHALL have port req_addr_i  in  NUM_REQ x ADDR_WIDTH  target register.
REQ-009 SHALL have port req_data_i  in  NUM_REQ x DATA_WIDTH  write data.
REQ-010 SHALL have ports we_a_o / waddr_a_o / wdata_a_o  out  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port A.
REQ-011 SHALL have ports we_b_o / waddr_b_o / wdata_b_o  out  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port B.
REQ-012 SHALL have port pending_o  out  2**ADDR_WIDTH  per-register "write outstanding" bits.
REQ-013 SHALL have port busy_o  out  1  high while any FIFO is non-empty.

Function
REQ-014 SHALL accept a request on a clk_int edge where req_valid_i and req_ready_o are both high, and push {addr, data} into that requester's FIFO.
REQ-015 SHALL preserve per-requester write order.
REQ-016 SHALL each cycle grant up to two non-empty FIFO heads in round-robin order starting at pointer rr_q: first grant goes to port A, second to port B.
REQ-017 SHALL NOT grant to port B any head whose address equals the port A grant address; the head stays queued and the next eligible head is taken instead.
REQ-018 SHALL pop a head whose address is 0 without asserting any we, and that pop SHALL consume a grant slot.
REQ-019 SHALL register all port outputs, so a write accepted on edge N into an empty FIFO with no contention drives we high in cycle N+1.
REQ-020 SHALL drive we_x_o low, and hold waddr_x_o and wdata_x_o at their previous values, in cycles with no grant for that port.
REQ-021 SHALL advance rr_q, modulo NUM_REQ, to the requester after the last granted one, and hold rr_q when nothing is granted.
REQ-022 SHALL permit push and pop on the same FIFO in the same cycle when full; req_ready_o SHALL still reflect the pre-pop full state.
REQ-023 SHALL set pending_o[a] while any queued FIFO entry targets address a, and clear it on the edge that pops the last such entry; bit 0 SHALL always be 0.
REQ-024 SHALL drive busy_o as the combinational OR of the FIFO non-empty flags.

Reset
REQ-025 SHALL, on rst_n low, asynchronously empty all FIFOs and set rr_q=0, we_a_o=we_b_o=0, waddr_*=0, wdata_*=0 and pending_o=0.
REQ-026 SHALL discard in-flight entries if reset is asserted mid-operation; no write SHALL be issued for them after reset release.
REQ-027 SHALL drive req_ready_o high from the first cycle after reset release.

Configuration
REQ-028 SHALL compile in the pending_o scoreboard when CV32E40P_RF_ARB_SCOREBOARD_EN is defined.
REQ-029 SHALL, when CV32E40P_RF_ARB_SCOREBOARD_EN is not defined, tie pending_o to 0 and instantiate no scoreboard logic; all other behaviour SHALL be identical.

Structure
REQ-030 SHALL take from package cv32e40p_rf_arb_pkg the typedef rf_wreq_t {addr, data}, the requester index constants REQ_ALU, REQ_LSU and REQ_APU, and the default FIFO_DEPTH.
REQ-031 SHALL implement each buffer as one instance of sub-module cv32e40p_rf_arb_fifo (synchronous push/pop, full/empty flags, head output, asynchronous rst_n).

Verification
REQ-032 SHALL cover: single ALU write addr=5 data=0xDEADBEEF into idle block -> we_a_o=1, waddr_a_o=5 in the next cycle; we_b_o=0.
REQ-033 SHALL cover: ALU addr=3 and LSU addr=3 valid together with rr_q=0 -> ALU's write on port A; LSU's write on port A the next cycle; port B idle both cycles.
REQ-034 SHALL cover: all three requesters valid every cycle with distinct addresses for 12 cycles -> grants rotate A/B pairs (0,1),(2,0),(1,2),...; no requester is starved.
REQ-035 SHALL cover: LSU issues 3 back-to-back writes while stalled by contention -> req_ready_o[1]=0 after 2 accepted; all writes emerge in order.
REQ-036 SHALL cover: write to addr 0 -> no we asserted; busy_o drops after 1 cycle.
REQ-037 SHALL cover: APU write addr=40 queued, rst_n pulsed low -> pending_o[40]=0, no write issued, busy_o=0; with scoreboard compiled out, pending_o=0 throughout.
